// File: rtl/scan_state_top.sv
// scan_state_top
// Acquisition-timing sequencer for the NMR front end. Two engines share one
// clock:
//   scan engine  : CONF (DDS setup) -> WAITP (wait transmit pulse end) ->
//                  DUMP (ring-down) -> ACQ (echo) -> INT (DSP interrupt),
//                  looping back to WAITP while scanstart stays high.
//   noise engine : N_SETTLE -> N_WIN (noise-only window) -> N_INT, one
//                  window per noisestart rise.
// n_s_change picks which engine drives the shared acquisition outputs.
//
// Optional feature: define NOISE_ENGINE_EN to build the noise engine and the
// shared-output mux. Without it, n_en is 0, the shared outputs always come
// from the scan engine and all noise-side inputs are ignored.
//
// Ports:
//   timeclk              clock, rising edge
//   scanrst / noiserst   async active-high resets of each engine
//   scanstart            level; rise (seen in IDLE) starts a scan, low ends it
//   noisestart           level; rise (seen in IDLE) starts one noise window
//   n_s_change           shared-output select: 1 = noise, 0 = scan
//   ctrl                 1 = calibration scan (drives calctrl during ACQ)
//   pluse_acq            end of transmit pulse; only honoured in WAITP
//   scanload/scanchoice/datain   scan register write (0 = dump, 1 = acq len)
//   nload/nchoice/ndatain        noise register write (0 = window, 1 = settle)
//   outputs              registered phase outputs, 1-cycle after state entry;
//                        resetout = resets | 1-cycle pulse at ACQ/N_WIN entry
//
// Handshake note: there is no valid/ready traffic here; all inputs are
// sampled levels, and starts are qualified by rising-edge detection.
module scan_state_top #(
  parameter int CONF_CYC = 4,
  parameter int CNT_W    = 16
) (
  input  logic             timeclk,
  input  logic             scanrst,
  input  logic             noiserst,
  input  logic             scanstart,
  input  logic             noisestart,
  input  logic             n_s_change,
  input  logic             ctrl,
  input  logic             pluse_acq,
  input  logic             scanload,
  input  logic             scanchoice,
  input  logic             nload,
  input  logic             nchoice,
  input  logic [CNT_W-1:0] datain,
  input  logic [CNT_W-1:0] ndatain,
  output logic             dds_conf,
  output logic             calctrl,
  output logic             s_acq,
  output logic             soft_d,
  output logic             sw_acq2,
  output logic             sw_acq1,
  output logic             intertodsp,
  output logic             rt_sw,
  output logic             n_en,
  output logic             resetout,
  output logic             dump_on,
  output logic             dump_off
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CONF_LOAD = CNT_W'(CONF_CYC - 1);

  // Counters count down to 0, so a phase of length n loads n-1.
  // A stored length of 0 is treated as 1.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : (len - ONE);
  endfunction

  // ---------------------------------------------------------------- scan
  typedef enum logic [2:0] {
    S_IDLE, S_CONF, S_WAITP, S_DUMP, S_ACQ, S_INT
  } scan_state_t;

  scan_state_t      scan_state;
  logic [CNT_W-1:0] dump_len, acq_len, scan_cnt;
  logic             scan_prev;   // previous scanstart, for edge detection
  logic             scan_first;  // high in the first cycle of DUMP / ACQ
  logic             sc_dds, sc_cal, sc_acq, sc_soft, sc_int;
  logic             sc_don, sc_doff, sc_pulse;

  always_ff @(posedge timeclk or posedge scanrst) begin
    if (scanrst) begin
      scan_state <= S_IDLE;
      dump_len   <= '0;
      acq_len    <= '0;
      scan_cnt   <= '0;
      // Reset to 1 so a scanstart already high at release is not a rise.
      scan_prev  <= 1'b1;
      scan_first <= 1'b0;
      sc_dds     <= 1'b0;
      sc_cal     <= 1'b0;
      sc_acq     <= 1'b0;
      sc_soft    <= 1'b0;
      sc_int     <= 1'b0;
      sc_don     <= 1'b0;
      sc_doff    <= 1'b0;
      sc_pulse   <= 1'b0;
    end else begin
      scan_prev  <= scanstart;
      scan_first <= 1'b0;
      if (scanload) begin
        if (scanchoice) acq_len  <= datain;
        else            dump_len <= datain;
      end

      // Outputs follow the current state, one cycle behind state entry.
      sc_dds   <= (scan_state == S_CONF);
      sc_soft  <= (scan_state == S_DUMP);
      sc_don   <= (scan_state == S_DUMP) && scan_first;
      sc_doff  <= (scan_state == S_DUMP) && (scan_cnt == '0);
      sc_acq   <= (scan_state == S_ACQ);
      sc_cal   <= (scan_state == S_ACQ) && ctrl;
      sc_pulse <= (scan_state == S_ACQ) && scan_first;
      sc_int   <= (scan_state == S_INT);

      case (scan_state)
        S_IDLE: begin
          if (scanstart && !scan_prev) begin
            scan_state <= S_CONF;
            scan_cnt   <= CONF_LOAD;
          end
        end
        S_CONF: begin
          if (scan_cnt == '0) scan_state <= S_WAITP;
          else                scan_cnt   <= scan_cnt - ONE;
        end
        S_WAITP: begin
          if (pluse_acq) begin
            scan_state <= S_DUMP;
            scan_cnt   <= load_val(dump_len);
            scan_first <= 1'b1;
          end else if (!scanstart) begin
            scan_state <= S_IDLE;
          end
        end
        S_DUMP: begin
          if (scan_cnt == '0) begin
            scan_state <= S_ACQ;
            scan_cnt   <= load_val(acq_len);
            scan_first <= 1'b1;
          end else begin
            scan_cnt <= scan_cnt - ONE;
          end
        end
        S_ACQ: begin
          if (scan_cnt == '0) scan_state <= S_INT;
          else                scan_cnt   <= scan_cnt - ONE;
        end
        S_INT:   scan_state <= scanstart ? S_WAITP : S_IDLE;
        default: scan_state <= S_IDLE;
      endcase
    end
  end

  assign dds_conf = sc_dds;
  assign calctrl  = sc_cal;
  assign soft_d   = sc_soft;
  assign dump_on  = sc_don;
  assign dump_off = sc_doff;

`ifdef NOISE_ENGINE_EN
  // --------------------------------------------------------------- noise
  typedef enum logic [1:0] {
    N_IDLE, N_SETTLE, N_WIN, N_INT
  } noise_state_t;

  noise_state_t     noise_state;
  logic [CNT_W-1:0] win_len, settle_len, noise_cnt;
  logic             noise_prev, noise_first;
  logic             ns_rt, ns_win, ns_int, ns_pulse;

  always_ff @(posedge timeclk or posedge noiserst) begin
    if (noiserst) begin
      noise_state <= N_IDLE;
      win_len     <= '0;
      settle_len  <= '0;
      noise_cnt   <= '0;
      noise_prev  <= 1'b1;
      noise_first <= 1'b0;
      ns_rt       <= 1'b0;
      ns_win      <= 1'b0;
      ns_int      <= 1'b0;
      ns_pulse    <= 1'b0;
    end else begin
      noise_prev  <= noisestart;
      noise_first <= 1'b0;
      if (nload) begin
        if (nchoice) settle_len <= ndatain;
        else         win_len    <= ndatain;
      end

      ns_rt    <= (noise_state == N_SETTLE) || (noise_state == N_WIN);
      ns_win   <= (noise_state == N_WIN);
      ns_pulse <= (noise_state == N_WIN) && noise_first;
      ns_int   <= (noise_state == N_INT);

      case (noise_state)
        N_IDLE: begin
          if (noisestart && !noise_prev) begin
            noise_state <= N_SETTLE;
            noise_cnt   <= load_val(settle_len);
          end
        end
        N_SETTLE: begin
          if (noise_cnt == '0) begin
            noise_state <= N_WIN;
            noise_cnt   <= load_val(win_len);
            noise_first <= 1'b1;
          end else begin
            noise_cnt <= noise_cnt - ONE;
          end
        end
        N_WIN: begin
          if (noise_cnt == '0) noise_state <= N_INT;
          else                 noise_cnt   <= noise_cnt - ONE;
        end
        N_INT:   noise_state <= N_IDLE;
        default: noise_state <= N_IDLE;
      endcase
    end
  end

  // Both engines always run; n_s_change only steers the shared outputs.
  assign s_acq      = n_s_change ? ns_win : sc_acq;
  assign sw_acq1    = n_s_change ? ns_win : sc_acq;
  assign sw_acq2    = n_s_change ? 1'b0   : sc_acq;
  assign rt_sw      = n_s_change ? ns_rt  : sc_acq;
  assign intertodsp = n_s_change ? ns_int : sc_int;
  assign n_en       = ns_win;
  assign resetout   = scanrst | noiserst | sc_pulse | ns_pulse;
`else
  logic unused_noise;
  assign unused_noise = ^{noiserst, noisestart, n_s_change, nload, nchoice, ndatain};

  assign s_acq      = sc_acq;
  assign sw_acq1    = sc_acq;
  assign sw_acq2    = sc_acq;
  assign rt_sw      = sc_acq;
  assign intertodsp = sc_int;
  assign n_en       = 1'b0;
  assign resetout   = scanrst | sc_pulse;
`endif

endmodule

// File: tb/tb_scan_state_top.sv
// Bench for scan_state_top. Each randomized scenario is planned as a set of
// phase segments (conf/wait/dump/acq/int for scan, settle/window/int for
// noise); expected output vectors per cycle are painted from those segments
// and the register lengths the bench wrote, then compared every cycle.
module tb_scan_state_top;

  localparam int MAXC = 160;
  localparam int B_DDS = 11, B_CAL = 10, B_SACQ = 9, B_SOFT = 8, B_SW2 = 7, B_SW1 = 6;
  localparam int B_INT = 5, B_RT = 4, B_NEN = 3, B_RST = 2, B_DON = 1, B_DOFF = 0;

`ifdef NOISE_ENGINE_EN
  localparam bit NOISE_ON = 1'b1;
`else
  localparam bit NOISE_ON = 1'b0;
`endif

  localparam logic [11:0] ACQ_BITS = (12'b1 << B_SACQ) | (12'b1 << B_SW2) |
                                     (12'b1 << B_SW1) | (12'b1 << B_RT);
  localparam logic [11:0] WIN_BITS = (12'b1 << B_NEN) | (12'b1 << B_SACQ) |
                                     (12'b1 << B_SW1) | (12'b1 << B_RT);
  localparam logic [11:0] MUX_MASK = ACQ_BITS | (12'b1 << B_INT);
  localparam logic [11:0] RST_BIT  = 12'b1 << B_RST;
  localparam logic [11:0] CAL_BIT  = 12'b1 << B_CAL;

  // ---------------------------------------------------------- clock/reset
  logic timeclk = 1'b0;
  always #5 timeclk = ~timeclk;

  logic scanrst = 1'b1, noiserst = 1'b1;
  logic scanstart = 1'b0, noisestart = 1'b0, n_s_change = 1'b0, ctrl = 1'b0;
  logic pluse_acq = 1'b0, scanload = 1'b0, scanchoice = 1'b0;
  logic nload = 1'b0, nchoice = 1'b0;
  logic [15:0] datain = '0, ndatain = '0;
  logic dds_conf, calctrl, s_acq, soft_d, sw_acq2, sw_acq1, intertodsp, rt_sw;
  logic n_en, resetout, dump_on, dump_off;
  logic [11:0] obs;

  assign obs = {dds_conf, calctrl, s_acq, soft_d, sw_acq2, sw_acq1,
                intertodsp, rt_sw, n_en, resetout, dump_on, dump_off};

  scan_state_top dut (
    .timeclk(timeclk), .scanrst(scanrst), .noiserst(noiserst),
    .scanstart(scanstart), .noisestart(noisestart), .n_s_change(n_s_change),
    .ctrl(ctrl), .pluse_acq(pluse_acq), .scanload(scanload),
    .scanchoice(scanchoice), .nload(nload), .nchoice(nchoice),
    .datain(datain), .ndatain(ndatain),
    .dds_conf(dds_conf), .calctrl(calctrl), .s_acq(s_acq), .soft_d(soft_d),
    .sw_acq2(sw_acq2), .sw_acq1(sw_acq1), .intertodsp(intertodsp),
    .rt_sw(rt_sw), .n_en(n_en), .resetout(resetout), .dump_on(dump_on),
    .dump_off(dump_off)
  );

  // ----------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  // Model register contents (as written by the bench).
  int m_dump = 0, m_acq = 0, m_settle = 0, m_win = 0;

  // Per-cycle plan for one scenario.
  logic [11:0] sc_v [MAXC];
  logic [11:0] no_v [MAXC];
  bit st_s [MAXC], st_p [MAXC], st_n [MAXC], st_ld [MAXC], st_ch [MAXC];
  logic [15:0] st_d [MAXC];

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [11:0] combine(input logic [11:0] sc, input logic [11:0] no,
                                          input bit nsc);
    logic [11:0] shared;
    shared = (nsc && NOISE_ON) ? (no & MUX_MASK) : (sc & MUX_MASK);
    return shared | (sc & ~MUX_MASK) | (no & ~MUX_MASK);
  endfunction

  // ---------------------------------------------------------- driver tasks
  task automatic wr_scan(input bit ch, input int v);
    @(negedge timeclk);
    scanload = 1'b1; scanchoice = ch; datain = 16'(v);
    @(posedge timeclk); #1;
    check_eq("wr_scan_idle", obs, 12'h000);
    scanload = 1'b0;
    if (ch) m_acq = v; else m_dump = v;
  endtask

  task automatic wr_noise(input bit ch, input int v);
    @(negedge timeclk);
    nload = 1'b1; nchoice = ch; ndatain = 16'(v);
    @(posedge timeclk); #1;
    check_eq("wr_noise_idle", obs, 12'h000);
    nload = 1'b0;
    if (ch) m_settle = v; else m_win = v;
  endtask

  task automatic clear_plan();
    for (int c = 0; c < MAXC; c++) begin
      sc_v[c] = '0; no_v[c] = '0; st_s[c] = 0; st_p[c] = 0; st_n[c] = 0;
      st_ld[c] = 0; st_ch[c] = 0; st_d[c] = '0;
    end
  endtask

  task automatic run_scenario(input int idx);
    int a, b, j, p, d, l, a0, ii, g, echoes, end_mode, drop, last_hi;
    int end_s, end_n, cur_acq, ts, tw, nv, n_cyc;
    bit do_scan, do_noise, c_ctrl, c_nsc;
    clear_plan();
    wr_scan(1'b0, $urandom_range(0, 4));
    wr_scan(1'b1, $urandom_range(0, 6));
    wr_noise(1'b0, $urandom_range(0, 5));
    wr_noise(1'b1, $urandom_range(0, 3));
    c_ctrl   = 1'($urandom_range(0, 1));
    c_nsc    = 1'($urandom_range(0, 1));
    do_scan  = (idx % 5 != 4);
    do_noise = (idx % 3 != 0);
    a = $urandom_range(0, 3);
    b = (idx % 4 == 1) ? a : $urandom_range(0, 3);
    end_s = 0; end_n = 0;

    if (do_scan) begin
      cur_acq = m_acq;
      echoes = $urandom_range(1, 3);
      end_mode = $urandom_range(0, 1);
      last_hi = a;
      for (int k = 1; k <= 4; k++) begin
        sc_v[a+k][B_DDS] = 1'b1;
        st_p[a+k] = 1'($urandom_range(0, 1));   // ignored outside the wait phase
      end
      j = a + 5;
      for (int e = 0; e < echoes; e++) begin
        g = $urandom_range(0, 3);
        p = j + g;
        st_p[p] = 1'b1;
        d = eff(m_dump);
        for (int k = 1; k <= d; k++) begin
          sc_v[p+k][B_SOFT] = 1'b1;
          st_p[p+k] = 1'($urandom_range(0, 1));
        end
        sc_v[p+1][B_DON] = 1'b1;
        sc_v[p+d][B_DOFF] = 1'b1;
        l = eff(cur_acq);
        a0 = p + d + 1;
        for (int k = 0; k < l; k++) begin
          sc_v[a0+k] = sc_v[a0+k] | ACQ_BITS | (c_ctrl ? CAL_BIT : 12'h000);
          st_p[a0+k] = 1'($urandom_range(0, 1));
        end
        sc_v[a0][B_RST] = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          // Rewrite acq length mid-phase: only later echoes see it.
          nv = $urandom_range(0, 6);
          st_ld[a0] = 1'b1; st_ch[a0] = 1'b1; st_d[a0] = 16'(nv);
          cur_acq = nv;
        end
        ii = a0 + l;
        sc_v[ii][B_INT] = 1'b1;
        st_p[ii] = 1'($urandom_range(0, 1));
        if (e == echoes - 1) begin
          if (end_mode == 0) begin
            drop = a0 + $urandom_range(0, l - 1);   // scanstart falls during acq
            end_s = ii + 1;
          end else begin
            drop = ii + 1 + $urandom_range(0, 2);   // falls while waiting
            end_s = drop + 1;
          end
          last_hi = drop - 1;
        end else begin
          j = ii + 1;
        end
      end
      for (int c = a; c <= last_hi; c++) st_s[c] = 1'b1;
      m_acq = cur_acq;
    end

    if (do_noise) begin
      ts = eff(m_settle);
      tw = eff(m_win);
      end_n = b + ts + tw + 2;
      for (int c = b; c <= end_n; c++) st_n[c] = 1'b1;
      if (NOISE_ON) begin
        for (int k = 1; k <= ts; k++) no_v[b+k][B_RT] = 1'b1;
        for (int k = 1; k <= tw; k++) no_v[b+ts+k] = no_v[b+ts+k] | WIN_BITS;
        no_v[b+ts+1][B_RST] = 1'b1;
        no_v[b+ts+tw+1][B_INT] = 1'b1;
      end
    end

    n_cyc = ((end_s > end_n) ? end_s : end_n) + 4;
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge timeclk);
      scanstart = st_s[c]; pluse_acq = st_p[c]; noisestart = st_n[c];
      scanload = st_ld[c]; scanchoice = st_ch[c]; datain = st_d[c];
      ctrl = c_ctrl; n_s_change = c_nsc;
      exp_q.push_back(combine(sc_v[c], no_v[c], c_nsc));
      @(posedge timeclk); #1;
      check_eq($sformatf("scen%0d_cyc%0d", idx, c), obs, exp_q.pop_front());
    end
    scanload = 1'b0;
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    scanstart = 1'b1;                      // held high through reset
    repeat (2) @(posedge timeclk);
    #1 check_eq("reset_hold", obs, RST_BIT);

    @(negedge timeclk);
    scanrst = 1'b0; noiserst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge timeclk); #1;
      check_eq("no_rise_no_start", obs, 12'h000);
    end
    @(negedge timeclk);
    scanstart = 1'b0;
    @(posedge timeclk); #1;
    check_eq("idle_after_release", obs, 12'h000);

    @(negedge timeclk);
    noiserst = 1'b1;
    #1 check_eq("noiserst_only", obs, NOISE_ON ? RST_BIT : 12'h000);
    @(negedge timeclk);
    noiserst = 1'b0;

    for (int s = 0; s < 30; s++) run_scenario(s);

    // Async reset in the middle of a long acquisition.
    wr_scan(1'b0, 2);
    wr_scan(1'b1, 20);
    ctrl = 1'b0; n_s_change = 1'b0;
    @(negedge timeclk);
    scanstart = 1'b1;
    repeat (5) @(negedge timeclk);
    pluse_acq = 1'b1;
    @(negedge timeclk);
    pluse_acq = 1'b0;
    repeat (3) @(negedge timeclk);
    @(posedge timeclk); #1;
    check_eq("mid_acq", obs, ACQ_BITS);
    #2;
    scanrst = 1'b1; noiserst = 1'b1;
    #1 check_eq("async_rst_mid_acq", obs, RST_BIT);
    @(negedge timeclk);
    scanstart = 1'b0; scanrst = 1'b0; noiserst = 1'b0;
    @(posedge timeclk); #1;
    check_eq("post_async_rst", obs, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_state_top.md
Name: scan_state_top

Overview:
- Acquisition-timing sequencer for the NMR front end, with two engines on one clock.
- Scan engine: steps through DDS configuration, ring-down dump, echo acquisition and the DSP interrupt for each echo.
- Noise engine: runs noise-only acquisition windows.
- n_s_change selects which engine drives the shared acquisition outputs.

Parameters:
- CONF_CYC, 4, cycles dds_conf is held after scan start.
- CNT_W, 16, width of the load buses and internal counters.

Ports:
- timeclk  in  1  system clock, rising edge.
- scanrst  in  1  asynchronous active-high reset of the scan engine.
- noiserst  in  1  asynchronous active-high reset of the noise engine.
- scanstart  in  1  level; rising edge starts a scan, low ends it.
- noisestart  in  1  level; rising edge starts one noise window.
- n_s_change  in  1  shared-output select: 1=noise, 0=scan.
- ctrl  in  1  1 = calibration scan.
- pluse_acq  in  1  end of transmit pulse, from the pulse sequencer.
- scanload  in  1  write strobe for the scan registers.
- scanchoice  in  1  scan register select: 0=dump length, 1=acquisition length.
- nload  in  1  write strobe for the noise registers.
- nchoice  in  1  noise register select: 0=window length, 1=settle length.
- datain  in  16  scan register data.
- ndatain  in  16  noise register data.
- dds_conf, calctrl, s_acq, soft_d, sw_acq2, sw_acq1, intertodsp, rt_sw, n_en, resetout, dump_on, dump_off  out  1 each.

Behaviour:
- Reset: while scanrst is high, all scan registers, the scan FSM and its outputs are 0. noiserst does the same for the noise side and n_en.
- resetout = scanrst | noiserst, combinational. It also pulses for 1 cycle at every ACQ/N_WIN entry.
- Register writes: on a clock edge with scanload=1, datain is written to the register selected by scanchoice (same for nload/nchoice/ndatain). Writes are allowed at any time. Counters sample the registers at phase entry, so a write mid-phase affects the next phase. A stored value of 0 behaves as 1.
- Start detection: scanstart and noisestart are edge-detected with a registered previous value. Only a 0->1 edge seen while the engine is in IDLE starts it.
- Scan FSM:
  - IDLE -> CONF on a scanstart rise.
  - CONF: dds_conf=1 for CONF_CYC cycles, then WAITP.
  - WAITP: leave on pluse_acq=1 -> DUMP. If scanstart is 0 -> IDLE.
  - DUMP: lasts dump-length cycles. dump_on pulses in the first cycle and dump_off in the last cycle (both in the same cycle when the length is 1). soft_d=1 throughout. Then ACQ.
  - ACQ: lasts acq-length cycles with s_acq=sw_acq1=sw_acq2=rt_sw=1, and calctrl=ctrl. Then INT.
  - INT: intertodsp=1 for 1 cycle. Then WAITP if scanstart=1, else IDLE.
  - Scan outputs are registered (1-cycle latency from state entry).
- Noise FSM:
  - IDLE -> N_SETTLE on a noisestart rise.
  - N_SETTLE: lasts settle-length cycles with rt_sw=1.
  - N_WIN: lasts window-length cycles with n_en=1 and noise-side s_acq=sw_acq1=rt_sw=1, sw_acq2=0.
  - N_INT: 1 cycle with noise-side intertodsp=1. Then IDLE.
- Shared-output mux: s_acq, sw_acq1, sw_acq2, rt_sw and intertodsp come from the noise engine when n_s_change=1, else from the scan engine. dds_conf, calctrl, soft_d, dump_on and dump_off always come from the scan engine. n_en is always driven by the noise engine.
- Both engines keep running whatever n_s_change is; the mux only selects outputs. Toggling n_s_change mid-phase switches outputs on the next cycle.
- Simultaneous scanstart rise and noisestart rise: both engines start.
- pluse_acq outside WAITP is ignored.

Optional Feature:
- Macro NOISE_ENGINE_EN.
- Defined: noise engine and output mux as described.
- Undefined: no noise logic. n_en=0, shared outputs always come from scan, and noisestart, nload, nchoice, ndatain, n_s_change and noiserst are ignored (resetout = scanrst only).

Test Plan:
1. Reset: scanrst=noiserst=1 asynchronously, mid-ACQ -> every output 0 immediately except resetout=1. Release -> all 0, FSMs in IDLE.
2. Load dump=3, acq=5. Raise scanstart, then pluse_acq for 1 cycle after CONF -> dds_conf high 4 cycles; dump_on/soft_d/dump_off over 3 cycles; s_acq/sw_acq1/sw_acq2/rt_sw high 5 cycles; intertodsp 1 cycle; return to WAITP.
3. Same run with ctrl=1 -> calctrl high exactly during the 5 ACQ cycles. With ctrl=0, calctrl stays 0.
4. Load dump=0 -> DUMP lasts 1 cycle, with dump_on and dump_off both in that cycle.
5. n_s_change=1, noise settle=2, window=4, noisestart rise -> rt_sw high 6 cycles; n_en/s_acq/sw_acq1 high 4 cycles; sw_acq2=0; intertodsp pulses once.
6. Drop scanstart during ACQ -> ACQ and INT complete, then IDLE. A scanstart held high from reset with no rising edge never starts a scan.
